// File: rtl/hazard_interlock_ctrl.sv
// Scoreboard interlock and flush sequencer for the 16-bit pipelined core.
// Tracks in-flight register writes between decode and writeback, stalls decode on
// read-after-write hazards and squashes wrong-path instructions after taken control flow.
module hazard_interlock_ctrl #(
  parameter int unsigned ASIZE        = 4,
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned RF_BYPASS    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [ASIZE-1:0]      id_raddr1_i,
  input  logic [ASIZE-1:0]      id_raddr2_i,
  input  logic                  id_use1_i,
  input  logic                  id_use2_i,
  input  logic                  id_wen_i,
  input  logic [ASIZE-1:0]      id_waddr_i,
  input  logic                  id_jump_i,
  input  logic                  exe_br_taken_i,
  output logic                  stall_o,
  output logic                  flush_id_o,
  output logic                  flush_exe_o,
  output logic [2**ASIZE-1:0]   pending_mask_o,
  output logic [15:0]           stall_cnt_o,
  output logic [15:0]           flush_cnt_o
);

  localparam int unsigned NumRegs  = 2**ASIZE;
  // With a write-through regfile the oldest shadow entry is already visible to decode.
  localparam int unsigned ChkDepth = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;
  localparam int unsigned CntW     = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CntW-1:0] FcntLoad = CntW'(FLUSH_CYCLES - 1);
  localparam logic [CntW-1:0] FcntOne  = CntW'(1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e          state_q;
  logic [CntW-1:0] fcnt_q;

  logic [DEPTH-1:0] sh_v_q, sh_v_d;
  logic [ASIZE-1:0] sh_a_q [DEPTH];
  logic [ASIZE-1:0] sh_a_d [DEPTH];

  logic        raw_prev_q;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic               hit1, hit2, raw;
  logic               br_flush, stall, flush_id;
  logic [NumRegs-1:0] pending;

  // Hazard detection against the shadow entries decode cannot yet read from the regfile.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < int'(ChkDepth); i++) begin
      if (sh_v_q[i] && (sh_a_q[i] == id_raddr1_i)) hit1 = 1'b1;
      if (sh_v_q[i] && (sh_a_q[i] == id_raddr2_i)) hit2 = 1'b1;
    end
    raw = id_valid_i & ((id_use1_i & hit1) | (id_use2_i & hit2));
  end

  // Flush/stall arbitration: branch or flush window beats RAW stall, which beats a jump.
  always_comb begin
    br_flush = exe_br_taken_i | (state_q == StFlush);
    // A jump held in decode by a stall only squashes its shadow slot once it issues.
    flush_id = br_flush | (id_jump_i & ~raw);
    stall    = raw & ~flush_id;
  end

  // Pending mask covers every valid entry, including the one the regfile bypasses.
  always_comb begin
    pending = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sh_v_q[i]) pending[sh_a_q[i]] = 1'b1;
    end
  end

  // Shadow pipeline next state: always shifts, stalled or squashed slots enter as bubbles.
  always_comb begin
    sh_v_d[0] = id_valid_i & id_wen_i & ~stall & ~flush_id;
    sh_a_d[0] = id_waddr_i;
    for (int i = 1; i < int'(DEPTH); i++) begin
      sh_v_d[i] = sh_v_q[i-1];
      sh_a_d[i] = sh_a_q[i-1];
    end
  end

  // Saturating event counters next state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_id && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Shadow register update.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sh_v_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) sh_a_q[i] <= '0;
    end else begin
      sh_v_q <= sh_v_d;
      for (int i = 0; i < int'(DEPTH); i++) sh_a_q[i] <= sh_a_d[i];
    end
  end

  // Flush sequencer: holds flush_id for FLUSH_CYCLES after a taken branch, reloading on re-taken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      fcnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (exe_br_taken_i && (FLUSH_CYCLES > 1)) begin
            state_q <= StFlush;
            fcnt_q  <= FcntLoad;
          end
        end
        StFlush: begin
          if (exe_br_taken_i) begin
            fcnt_q <= FcntLoad;
          end else if (fcnt_q == FcntOne) begin
            state_q <= StIdle;
            fcnt_q  <= '0;
          end else begin
            fcnt_q <= fcnt_q - FcntOne;
          end
        end
        default: begin
          state_q <= StIdle;
          fcnt_q  <= '0;
        end
      endcase
    end
  end

  // Previous-cycle stall and counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      raw_prev_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      raw_prev_q  <= stall;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // An op that was stalled right up to the branch cycle has slipped into EXE; kill it in DM.
  assign flush_exe_o    = exe_br_taken_i & raw_prev_q;
  assign stall_o        = stall;
  assign flush_id_o     = flush_id;
  assign pending_mask_o = pending;
  assign stall_cnt_o    = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;

endmodule
